// File: rtl/video_timing_pkg.sv
// Shared timing description for the raster generator: one axis of video
// timing as a struct, a few standard modes, and a helper that sums an axis.
package video_timing_pkg;

   typedef struct packed {
      int unsigned active;
      int unsigned front;
      int unsigned sync;
      int unsigned back;
   } timing_t;

   localparam timing_t TIMING_720P_H = '{active: 1280, front: 110, sync: 40, back: 220};
   localparam timing_t TIMING_720P_V = '{active: 720,  front: 5,   sync: 5,  back: 20};
   localparam timing_t TIMING_480P_H = '{active: 640,  front: 16,  sync: 96, back: 48};
   localparam timing_t TIMING_480P_V = '{active: 480,  front: 10,  sync: 2,  back: 33};

   function automatic int unsigned timing_total(timing_t t);
      return t.active + t.front + t.sync + t.back;
   endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// Fixed-depth shift register used to align sync/DE with the render
// pipeline. DEPTH of 0 degenerates to a wire.
module sync_delay_line #(
   parameter int               WIDTH       = 3,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk | rst_n;
      assign q = d;
   end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // shift every cycle; reset loads the idle pattern into every stage
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
         end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         end
      end

      assign q = stage[DEPTH-1];
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counter with DVI sync/DE decode. x/y/active/frame_start are the
// undelayed raster; hs/vs/de come out LATENCY cycles later to match the
// renderer. en=0 parks the raster at the last pixel of the frame so that
// the first enabled edge always lands on (0,0).
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int HOR_ACTIVE_PIXELS = 1280,
   parameter int HOR_FRONT_PORCH   = 110,
   parameter int HOR_SYNC          = 40,
   parameter int HOR_BACK_PORCH    = 220,
   parameter int VER_ACTIVE_PIXELS = 720,
   parameter int VER_FRONT_PORCH   = 5,
   parameter int VER_SYNC          = 5,
   parameter int VER_BACK_PORCH    = 20,
   parameter bit HS_POLARITY       = 1'b1,
   parameter bit VS_POLARITY       = 1'b1,
   parameter int LATENCY           = 2,
   parameter int FRAME_CNT_WIDTH   = 8,
   localparam int H_TOTAL = int'(timing_total(timing_t'{
      active: HOR_ACTIVE_PIXELS, front: HOR_FRONT_PORCH,
      sync: HOR_SYNC, back: HOR_BACK_PORCH})),
   localparam int V_TOTAL = int'(timing_total(timing_t'{
      active: VER_ACTIVE_PIXELS, front: VER_FRONT_PORCH,
      sync: VER_SYNC, back: VER_BACK_PORCH})),
   localparam int X_WIDTH = $clog2(H_TOTAL),
   localparam int Y_WIDTH = $clog2(V_TOTAL)
) (
   input  logic                       clk_rgb,
   input  logic                       rst_n,
   input  logic                       en,
   output logic [X_WIDTH-1:0]         x,
   output logic [Y_WIDTH-1:0]         y,
   output logic                       active,
   output logic                       frame_start,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count,
   output logic                       hs,
   output logic                       vs,
   output logic                       de
);

   if (HOR_FRONT_PORCH == 0 || HOR_SYNC == 0 || HOR_BACK_PORCH == 0 ||
       VER_FRONT_PORCH == 0 || VER_SYNC == 0 || VER_BACK_PORCH == 0) begin : g_bad_timing
      $error("video_timing_gen: porch and sync widths must be nonzero");
   end

   // the delay line must drain before the next line's active region shows up
   if (LATENCY > HOR_FRONT_PORCH) begin : g_bad_latency
      $error("video_timing_gen: LATENCY must not exceed HOR_FRONT_PORCH");
   end

   localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(H_TOTAL - 1);
   localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(V_TOTAL - 1);
   localparam logic [X_WIDTH-1:0] X_ACT    = X_WIDTH'(HOR_ACTIVE_PIXELS);
   localparam logic [Y_WIDTH-1:0] Y_ACT    = Y_WIDTH'(VER_ACTIVE_PIXELS);
   localparam logic [X_WIDTH-1:0] X_SYNC_S = X_WIDTH'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
   localparam logic [X_WIDTH-1:0] X_SYNC_E = X_WIDTH'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC);
   localparam logic [Y_WIDTH-1:0] Y_SYNC_S = Y_WIDTH'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
   localparam logic [Y_WIDTH-1:0] Y_SYNC_E = Y_WIDTH'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC);

   logic [X_WIDTH-1:0]         x_q, x_d;
   logic [Y_WIDTH-1:0]         y_q, y_d;
   logic                       origin_d;
   logic                       run_q;
   logic                       frame_start_q;
   logic [FRAME_CNT_WIDTH-1:0] frame_count_q;
   logic                       hsync_raw, vsync_raw;
   logic                       hs_lvl, vs_lvl;
   logic [2:0]                 dly_q;

   // next raster position: advance while enabled, otherwise snap to park
   always_comb begin
      x_d = X_LAST;
      y_d = Y_LAST;
      if (en) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
            y_d = y_q;
         end
      end
      origin_d = en && (x_d == '0) && (y_d == '0);
   end

   // raster registers; run_q marks that the frame now ending was begun while
   // enabled, so only genuinely completed frames are counted
   always_ff @(posedge clk_rgb or negedge rst_n) begin
      if (!rst_n) begin
         x_q           <= X_LAST;
         y_q           <= Y_LAST;
         run_q         <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         run_q         <= en;
         frame_start_q <= origin_d;
         if (origin_d && run_q) frame_count_q <= frame_count_q + 1'b1;
      end
   end

   assign active    = (x_q < X_ACT) && (y_q < Y_ACT);
   assign hsync_raw = (x_q >= X_SYNC_S) && (x_q < X_SYNC_E);
   assign vsync_raw = (y_q >= Y_SYNC_S) && (y_q < Y_SYNC_E);
   assign hs_lvl    = hsync_raw ~^ HS_POLARITY;
   assign vs_lvl    = vsync_raw ~^ VS_POLARITY;

   sync_delay_line #(
      .WIDTH       (3),
      .DEPTH       (LATENCY),
      .RESET_VALUE ({1'b0, ~HS_POLARITY, ~VS_POLARITY})
   ) u_sync_delay (
      .clk   (clk_rgb),
      .rst_n (rst_n),
      .d     ({active, hs_lvl, vs_lvl}),
      .q     (dly_q)
   );

   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;
   assign {de, hs, vs} = dly_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised successor to pixel_iterator. Generates raster counters and DVI sync/DE from fully parametrised horizontal and vertical timing, with selectable sync polarity. Drives dvi_tx through a LATENCY-cycle delay line, so the render pipeline's per-pixel latency is matched without extra glue. Adds a frame-start pulse, a frame counter and a run/park enable. Sits between rgb_clock_pll/clk_rgb and the renderer plus dvi_tx in logic_top.

Parameters:
HOR_ACTIVE_PIXELS, 1280, visible pixels per line
HOR_FRONT_PORCH, 110, pixels between active and hsync
HOR_SYNC, 40, hsync width in pixels
HOR_BACK_PORCH, 220, pixels between hsync and next active
VER_ACTIVE_PIXELS, 720, visible lines
VER_FRONT_PORCH, 5, lines between active and vsync
VER_SYNC, 5, vsync width in lines
VER_BACK_PORCH, 20, lines between vsync and next active
HS_POLARITY, 1, 1 means hs is high during sync
VS_POLARITY, 1, 1 means vs is high during sync
LATENCY, 2, cycles hs/vs/de lag x/y/active; 0 is legal
FRAME_CNT_WIDTH, 8, frame counter width
Derived: H_TOTAL = sum of HOR_*, V_TOTAL = sum of VER_*, X_WIDTH = $clog2(H_TOTAL), Y_WIDTH = $clog2(V_TOTAL).

Ports:
clk_rgb  input  1  pixel clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  1 runs the raster; 0 parks it
x  output  X_WIDTH  horizontal counter, current pixel
y  output  Y_WIDTH  vertical counter, current line
active  output  1  high when x < HOR_ACTIVE_PIXELS and y < VER_ACTIVE_PIXELS (from x/y combinationally)
frame_start  output  1  one-cycle pulse while x=0, y=0
frame_count  output  FRAME_CNT_WIDTH  completed-frame count, wraps
hs  output  1  horizontal sync to dvi_tx, delayed by LATENCY
vs  output  1  vertical sync to dvi_tx, delayed by LATENCY
de  output  1  data enable to dvi_tx, delayed by LATENCY

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low: rst_n low clears all state immediately.
- Reset values:
  - x = H_TOTAL-1, y = V_TOTAL-1 (park position, in blanking).
  - frame_start = 0, frame_count = 0.
  - Every delay stage is loaded with de=0 and inactive hs/vs, so de=0, hs=!HS_POLARITY, vs=!VS_POLARITY.
- Counting when en=1, per clock:
  - x increments; at x = H_TOTAL-1, x wraps to 0.
  - y increments only when x wraps; at y = V_TOTAL-1 it wraps to 0 together with x.
- Park when en=0:
  - The next edge loads the park position and holds it; frame_count holds.
  - The delay line keeps shifting, so de, hs and vs reach idle levels LATENCY cycles later.
  - Deasserting en mid-frame abandons that frame; it is not counted.
- The first en=1 edge after park or reset yields x=0, y=0 with frame_start=1. Frames therefore always start cleanly.
- frame_start is a registered flag, set on the edge that loads (0,0).
- frame_count increments on the same edge as frame_start, except for the first frame after reset or park. It counts completed frames, wrapping at 2^FRAME_CNT_WIDTH.
- Raw sync decode from x/y:
  - hsync_raw when HOR_ACTIVE_PIXELS+HOR_FRONT_PORCH <= x < that value + HOR_SYNC.
  - vsync_raw when VER_ACTIVE_PIXELS+VER_FRONT_PORCH <= y < that value + VER_SYNC, over whole lines: vs edges align with x=0.
  - Output level is raw XNOR polarity, i.e. hs = HS_POLARITY ? hsync_raw : !hsync_raw (vs likewise).
- Delay line: LATENCY-deep shift register of {de, hs, vs}, always enabled. With LATENCY=0 the outputs are the combinational decode.
- Elaboration must fail if any porch or sync is 0, or if LATENCY > HOR_FRONT_PORCH.

Decomposition:
- Package video_timing_pkg: struct timing_t (active/front/sync/back for one axis), 720p and 480p timing constants, and a function returning the total of a timing_t.
- Sub-module sync_delay_line (WIDTH, DEPTH, RESET_VALUE): async active-low reset shift register, instantiated once for {de, hs, vs}.

Test Plan:
- Reset release, then en=1, defaults: first edge gives x=0, y=0, frame_start=1. de rises exactly 2 cycles later and stays high 1280 cycles.
- Defaults, one line: hs high for x in 1390..1429 plus 2-cycle lag. Line period is 1650 cycles. de low for 370 cycles per line.
- Defaults, one frame: vs high for lines 725..729 and starts aligned with x=0 plus lag. Frame period is 1650*750 = 1237500 cycles. frame_count 0 -> 1 at the second frame_start.
- HS_POLARITY=0, VS_POLARITY=0, LATENCY=0, 640x480 timing (16/96/48, 10/2/33): hs low for x in 656..751; vs low for lines 490..491; de coincident with active.
- en dropped at x=500, y=100: next edge gives x=1649, y=749; de=0 after LATENCY cycles; frame_count unchanged. On re-enable, x=0, y=0 and frame_start=1.
- rst_n asserted mid-line at x=700 with de=1: de=0, hs/vs inactive and x=1649 immediately (no clock needed); frame_count=0.
